// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch stage.
// The helper align_word clears byte-offset bits so fetch addresses stay word aligned.
package fetch_pkg;

   localparam logic [31:0] DEFAULT_NOP_WORD = 32'h0000_0000;
   localparam logic [31:0] PC_INC           = 32'd4;
   localparam logic [31:0] ADDR_ALIGN_MASK  = 32'hFFFF_FFFC;

   typedef enum logic [1:0] {
      PcSelReset,
      PcSelRedirect,
      PcSelHold,
      PcSelIncr
   } pc_sel_e;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc_plus4;
      logic        valid;
   } ifid_t;

   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return addr & ADDR_ALIGN_MASK;
   endfunction

endpackage

// File: rtl/pc_register.sv
// Program counter flop with its next-PC selection (reset / redirect / hold / increment).
// pc is a pure register output so downstream control never reaches the memory address port.
module pc_register
   import fetch_pkg::*;
#(
   parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_target,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4
);

   pc_sel_e     pc_sel;
   logic [31:0] pc_d;
   logic [31:0] pc_q;

   // Priority: reset > redirect > stall > increment.
   always_comb begin
      pc_sel = PcSelIncr;
      if (reset) begin
         pc_sel = PcSelReset;
      end else if (redirect) begin
         pc_sel = PcSelRedirect;
      end else if (stall) begin
         pc_sel = PcSelHold;
      end
   end

   always_comb begin
      pc_d = pc_q;
      unique case (pc_sel)
         PcSelReset:    pc_d = align_word(PC_RESET);
         PcSelRedirect: pc_d = align_word(redirect_target);
         PcSelHold:     pc_d = pc_q;
         PcSelIncr:     pc_d = pc_q + PC_INC;
         default:       pc_d = pc_q;
      endcase
   end

   always_ff @(posedge clk) begin
      pc_q <= pc_d;
   end

   assign pc       = pc_q;
   assign pc_plus4 = pc_q + PC_INC;

endmodule

// File: rtl/instruction_fetch_stage.sv
// MIPS IF stage: PC, fetch address, IF/ID register, stall and branch/jump redirect handling.
// Define FETCH_PERF_CNT_EN to add the FetchCount / BubbleCount performance counters.
module instruction_fetch_stage
   import fetch_pkg::*;
#(
   parameter logic [31:0] PC_RESET = 32'h0000_0000,
   parameter logic [31:0] NOP_WORD = fetch_pkg::DEFAULT_NOP_WORD
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Stall,
   input  logic        BranchTaken,
   input  logic [31:0] BranchTarget,
   input  logic        Jump,
   input  logic [31:0] JumpTarget,
   input  logic [31:0] Instruction,
   output logic [31:0] Address,
   output logic [31:0] IfIdInstruction,
   output logic [31:0] IfIdPCPlus4,
   output logic        IfIdValid
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] FetchCount,
   output logic [31:0] BubbleCount
`endif
);

   logic        redirect;
   logic [31:0] redirect_target;
   logic        advance;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   ifid_t       ifid_d;
   ifid_t       ifid_q;

   // Branch wins over jump: it belongs to the older instruction.
   assign redirect        = BranchTaken | Jump;
   assign redirect_target = BranchTaken ? BranchTarget : JumpTarget;
   assign advance         = ~redirect & ~Stall;

   pc_register #(
      .PC_RESET(PC_RESET)
   ) u_pc_register (
      .clk            (Clk),
      .reset          (Reset),
      .stall          (Stall),
      .redirect       (redirect),
      .redirect_target(redirect_target),
      .pc             (pc),
      .pc_plus4       (pc_plus4)
   );

   always_comb begin
      ifid_d = ifid_q;
      if (Reset || redirect) begin
         // Squash the wrong-path fetch with a bubble.
         ifid_d.instr    = NOP_WORD;
         ifid_d.pc_plus4 = 32'd0;
         ifid_d.valid    = 1'b0;
      end else if (advance) begin
         ifid_d.instr    = Instruction;
         ifid_d.pc_plus4 = pc_plus4;
         ifid_d.valid    = 1'b1;
      end
   end

   always_ff @(posedge Clk) begin
      ifid_q <= ifid_d;
   end

   assign Address         = pc;
   assign IfIdInstruction = ifid_q.instr;
   assign IfIdPCPlus4     = ifid_q.pc_plus4;
   assign IfIdValid       = ifid_q.valid;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_cnt_q;
   logic [31:0] bubble_cnt_q;

   // Every non-reset cycle is either an advance or a bubble (redirect or stall).
   always_ff @(posedge Clk) begin
      if (Reset) begin
         fetch_cnt_q  <= 32'd0;
         bubble_cnt_q <= 32'd0;
      end else if (advance) begin
         fetch_cnt_q  <= fetch_cnt_q + 32'd1;
      end else begin
         bubble_cnt_q <= bubble_cnt_q + 32'd1;
      end
   end

   assign FetchCount  = fetch_cnt_q;
   assign BubbleCount = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Scoreboard bench for instruction_fetch_stage: directed scenarios followed by random control.
// Two instances share stimulus: default reset PC and a reset PC at the top of the address space.
module tb_instruction_fetch_stage;

   localparam logic [31:0] NOP    = 32'h0000_0000;
   localparam logic [31:0] RST_B  = 32'hFFFF_FFFC;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ii;
      logic [31:0] ip4;
      logic        iv;
      logic [31:0] fc;
      logic [31:0] bc;
   } st_t;

   typedef struct packed {
      st_t a;
      st_t b;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset, stall, br, jmp;
   logic [31:0] bt, jt;
   logic [31:0] addr_a, instr_a, ii_a, ip4_a;
   logic [31:0] addr_b, instr_b, ii_b, ip4_b;
   logic        iv_a, iv_b;
   logic [31:0] mem [64];

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   st_t  ma, mb;

   always #5 clk = ~clk;

   assign instr_a = mem[addr_a[7:2]];
   assign instr_b = mem[addr_b[7:2]];

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fc_a, bc_a, fc_b, bc_b;
`endif

   instruction_fetch_stage dut_a (
      .Clk            (clk),
      .Reset          (reset),
      .Stall          (stall),
      .BranchTaken    (br),
      .BranchTarget   (bt),
      .Jump           (jmp),
      .JumpTarget     (jt),
      .Instruction    (instr_a),
      .Address        (addr_a),
      .IfIdInstruction(ii_a),
      .IfIdPCPlus4    (ip4_a),
      .IfIdValid      (iv_a)
`ifdef FETCH_PERF_CNT_EN
      ,
      .FetchCount     (fc_a),
      .BubbleCount    (bc_a)
`endif
   );

   instruction_fetch_stage #(
      .PC_RESET(RST_B)
   ) dut_b (
      .Clk            (clk),
      .Reset          (reset),
      .Stall          (stall),
      .BranchTaken    (br),
      .BranchTarget   (bt),
      .Jump           (jmp),
      .JumpTarget     (jt),
      .Instruction    (instr_b),
      .Address        (addr_b),
      .IfIdInstruction(ii_b),
      .IfIdPCPlus4    (ip4_b),
      .IfIdValid      (iv_b)
`ifdef FETCH_PERF_CNT_EN
      ,
      .FetchCount     (fc_b),
      .BubbleCount    (bc_b)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference: one clock edge of the fetch stage from the rules, with memory as a word array.
   function automatic st_t model(input st_t s, input logic [31:0] rpc);
      st_t n;
      n = s;
      if (reset) begin
         n.pc  = rpc;
         n.ii  = NOP;
         n.ip4 = 32'd0;
         n.iv  = 1'b0;
         n.fc  = 32'd0;
         n.bc  = 32'd0;
      end else if (br || jmp) begin
         n.pc  = (br ? bt : jt) & ~32'h3;
         n.ii  = NOP;
         n.ip4 = 32'd0;
         n.iv  = 1'b0;
         n.bc  = s.bc + 32'd1;
      end else if (stall) begin
         n.bc  = s.bc + 32'd1;
      end else begin
         n.ii  = mem[s.pc[7:2]];
         n.pc  = s.pc + 32'd4;
         n.ip4 = s.pc + 32'd4;
         n.iv  = 1'b1;
         n.fc  = s.fc + 32'd1;
      end
      return n;
   endfunction

   // Called at a falling edge; returns at the next falling edge with the DUT updated.
   task automatic step(input logic r, input logic s, input logic b, input logic [31:0] btv,
                       input logic j, input logic [31:0] jtv);
      exp_t e;
      #1;
      reset = r;
      stall = s;
      br    = b;
      bt    = btv;
      jmp   = j;
      jt    = jtv;
      ma    = model(ma, 32'h0000_0000);
      mb    = model(mb, RST_B);
      e.a   = ma;
      e.b   = mb;
      sb.push_back(e);
      @(negedge clk);
   endtask

   task automatic adv();
      step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check("a_addr", addr_a, e.a.pc);
         check("a_ifid_instr", ii_a, e.a.ii);
         check("a_ifid_pc4", ip4_a, e.a.ip4);
         check("a_ifid_valid", {31'd0, iv_a}, {31'd0, e.a.iv});
         check("b_addr", addr_b, e.b.pc);
         check("b_ifid_instr", ii_b, e.b.ii);
         check("b_ifid_pc4", ip4_b, e.b.ip4);
         check("b_ifid_valid", {31'd0, iv_b}, {31'd0, e.b.iv});
`ifdef FETCH_PERF_CNT_EN
         check("a_fetch_cnt", fc_a, e.a.fc);
         check("a_bubble_cnt", bc_a, e.a.bc);
         check("b_fetch_cnt", fc_b, e.b.fc);
         check("b_bubble_cnt", bc_b, e.b.bc);
`endif
      end
   end

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = $urandom;
      mem[0] = 32'h200A_0001;
      reset = 1'b1;
      stall = 1'b0;
      br    = 1'b0;
      jmp   = 1'b0;
      bt    = 32'd0;
      jt    = 32'd0;
      ma    = '0;
      mb    = '0;
      @(negedge clk);

      // Reset for two cycles, then the first fetch.
      step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      check("t1_rst_addr", addr_a, 32'd0);
      check("t1_rst_valid", {31'd0, iv_a}, 32'd0);
      check("t5_rst_addr", addr_b, 32'hFFFF_FFFC);
      adv();
      check("t1_instr", ii_a, 32'h200A_0001);
      check("t1_pc4", ip4_a, 32'd4);
      check("t1_valid", {31'd0, iv_a}, 32'd1);
      check("t1_addr", addr_a, 32'd4);
      check("t5_wrap_addr", addr_b, 32'd0);
      check("t5_wrap_pc4", ip4_b, 32'd0);

      // Three-cycle stall at Address 8.
      adv();
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
         check("t2_stall_addr", addr_a, 32'd8);
         check("t2_stall_pc4", ip4_a, 32'd8);
         check("t2_stall_instr", ii_a, mem[1]);
      end
      adv();
      check("t2_after_addr", addr_a, 32'd12);

      // Branch back from 16 to 8.
      adv();
      check("t3_pre_addr", addr_a, 32'd16);
      step(1'b0, 1'b0, 1'b1, 32'd8, 1'b0, 32'd0);
      check("t3_br_addr", addr_a, 32'd8);
      check("t3_br_valid", {31'd0, iv_a}, 32'd0);
      check("t3_br_instr", ii_a, NOP);
      adv();
      check("t3_next_valid", {31'd0, iv_a}, 32'd1);
      check("t3_next_instr", ii_a, mem[2]);

      // Branch, jump and stall together: branch wins.
      step(1'b0, 1'b1, 1'b1, 32'h40, 1'b1, 32'h80);
      check("t4_addr", addr_a, 32'h40);
      check("t4_valid", {31'd0, iv_a}, 32'd0);

      // Misaligned jump target.
      step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h0000_000B);
      check("t5_jmp_addr_a", addr_a, 32'd8);
      check("t5_jmp_addr_b", addr_b, 32'd8);

`ifdef FETCH_PERF_CNT_EN
      step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      for (int k = 0; k < 5; k++) adv();
      step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
      step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
      step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h20);
      check("t6_fetch_cnt", fc_a, 32'd5);
      check("t6_bubble_cnt", bc_a, 32'd3);
      step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      check("t6_rst_fetch", fc_a, 32'd0);
      check("t6_rst_bubble", bc_a, 32'd0);
`endif

      // Random control traffic.
      for (int k = 0; k < 400; k++) begin
         step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 25),
              ($urandom_range(0, 99) < 10), $urandom,
              ($urandom_range(0, 99) < 10), $urandom);
      end
      adv();

      #1;
      check("scoreboard_drained", sb.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
